// File: rtl/multi_bank_reader_pkg.sv
// Shared definitions for the port-B read sequencers: FSM state encoding and a width helper.
package multi_bank_reader_pkg;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned log2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/row_fifo.sv
// Synchronous row FIFO with flop-backed storage; head word is presented whenever non-empty.
module row_fifo
  import multi_bank_reader_pkg::*;
#(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PW = log2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW:0]      wr_ptr_q;
  logic [PW:0]      rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q[PW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PW-1:0]] <= din;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

endmodule

// File: rtl/multi_bank_reader.sv
// Port-B read sequencer: issues same-row reads to all banks and streams rows out over AXI-Stream.
// Define MULTI_BANK_READER_CHECK_EN to add the sticky err output for validb/overflow checking.
module multi_bank_reader
  import multi_bank_reader_pkg::*;
#(
  parameter int unsigned BANKS      = 4,
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR       = log2(DEPTH),
  parameter int unsigned LEN_W      = ADDR + 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDR-1:0]        base_addr,
  input  logic [LEN_W-1:0]       length,
  output logic                   busy,
  output logic                   done,
  output logic [BANKS-1:0]       enb,
  output logic [BANKS*ADDR-1:0]  addrb,
  input  logic [BANKS*WIDTH-1:0] doutb,
  input  logic [BANKS-1:0]       validb,
  output logic [BANKS*WIDTH-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast
`ifdef MULTI_BANK_READER_CHECK_EN
  ,
  output logic                   err
`endif
);

  localparam int unsigned CW = log2(FIFO_DEPTH) + 1;

  logic [1:0]       state_q, state_d;
  logic [ADDR-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0]    credits_q, credits_d;
  logic             done_q, done_d;
  logic             issue;
  logic             hs;
  logic             capture;
  logic             fifo_full;
  logic             fifo_empty;

  // Credits cover reads in flight plus rows held in the FIFO, so a capture always has room.
  assign issue         = (state_q == StIssue) && (credits_q < CW'(FIFO_DEPTH));
  assign hs            = m_axis_tvalid & m_axis_tready;
  assign capture       = (&validb) & ~fifo_full;
  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tlast  = m_axis_tvalid && (out_cnt_q == len_q - LEN_W'(1));
  assign enb           = {BANKS{issue}};
  assign addrb         = {BANKS{addr_q}};
  assign busy          = (state_q != StIdle);
  assign done          = done_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    len_d     = len_q;
    out_cnt_d = out_cnt_q;
    credits_d = credits_q;
    done_d    = 1'b0;

    if (issue && !hs)      credits_d = credits_q + 1'b1;
    else if (!issue && hs) credits_d = credits_q - 1'b1;

    if (hs) out_cnt_d = out_cnt_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d    = base_addr;
          len_d     = length;
          rem_d     = length;
          out_cnt_d = '0;
          if (length == '0) done_d  = 1'b1;
          else              state_d = StIssue;
        end
      end
      StIssue: begin
        if (issue) begin
          addr_d = (addr_q == ADDR'(DEPTH - 1)) ? '0 : addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == LEN_W'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if (hs && m_axis_tlast) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      rem_q     <= '0;
      len_q     <= '0;
      out_cnt_q <= '0;
      credits_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      len_q     <= len_d;
      out_cnt_q <= out_cnt_d;
      credits_q <= credits_d;
      done_q    <= done_d;
    end
  end

  row_fifo #(
    .WIDTH(BANKS * WIDTH),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (capture),
    .din  (doutb),
    .pop  (hs),
    .dout (m_axis_tdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

`ifdef MULTI_BANK_READER_CHECK_EN
  logic err_q;

  // Banks out of step, or a capture arriving with the FIFO already full.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_q <= 1'b0;
    end else if (((|validb) && !(&validb)) || ((&validb) && fifo_full)) begin
      err_q <= 1'b1;
    end
  end

  assign err = err_q;
`endif

endmodule

// File: tb/tb_multi_bank_reader.sv
// Scoreboard bench for multi_bank_reader with a one-cycle-latency bank model.
module tb_multi_bank_reader;

  localparam int unsigned BANKS = 4;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 256;
  localparam int unsigned ADDR  = 8;
  localparam int unsigned LEN_W = 9;
  localparam int unsigned FD    = 4;
  localparam int unsigned DW    = BANKS * WIDTH;

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic                  start = 1'b0;
  logic [ADDR-1:0]       base_addr = '0;
  logic [LEN_W-1:0]      length = '0;
  logic                  busy, done;
  logic [BANKS-1:0]      enb;
  logic [BANKS*ADDR-1:0] addrb;
  logic [DW-1:0]         doutb;
  logic [BANKS-1:0]      validb;
  logic [DW-1:0]         tdata;
  logic                  tvalid, tlast;
  logic                  tready = 1'b1;
  logic [DW-1:0]         rd_data = '0;
  logic [BANKS-1:0]      rd_valid = '0;
  logic                  force_en = 1'b0;
  logic [BANKS-1:0]      force_val = '0;
`ifdef MULTI_BANK_READER_CHECK_EN
  logic                  err;
`endif

  int total = 0;
  int bad = 0;
  int mode = 0;
  int occ = 0;
  int outst = 0;
  bit saw_stall = 1'b0;
  logic [DW:0] exp_q[$];
  int unsigned exp_addr_q[$];

  assign doutb  = rd_data;
  assign validb = force_en ? force_val : rd_valid;

  always #5 clk = ~clk;

  multi_bank_reader #(
    .BANKS(BANKS), .WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .LEN_W(LEN_W), .FIFO_DEPTH(FD)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .base_addr    (base_addr),
    .length       (length),
    .busy         (busy),
    .done         (done),
    .enb          (enb),
    .addrb        (addrb),
    .doutb        (doutb),
    .validb       (validb),
    .m_axis_tdata (tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .m_axis_tlast (tlast)
`ifdef MULTI_BANK_READER_CHECK_EN
    ,
    .err          (err)
`endif
  );

  // Bank b row r holds {b, r}; read data returns one cycle after enable.
  always @(posedge clk) begin
    for (int b = 0; b < BANKS; b++) begin
      rd_valid[b] <= enb[b];
      rd_data[b*WIDTH +: WIDTH] <= {8'(b), addrb[b*ADDR +: ADDR]};
    end
  end

  function automatic logic [DW-1:0] row_word(input int unsigned r);
    logic [DW-1:0] w;
    w = '0;
    for (int b = 0; b < BANKS; b++) w[b*WIDTH +: WIDTH] = {8'(b), 8'(r)};
    return w;
  endfunction

  task automatic chk(input string name, input logic [DW:0] act, input logic [DW:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: rows against the scoreboard, addresses against the issue order, credit/FIFO bounds.
  always @(negedge clk) begin
    logic [DW:0]           e;
    logic [BANKS*ADDR-1:0] ea;
    logic [ADDR-1:0]       a8;
    int                    hsv;
    if (!rstn) begin
      exp_q.delete();
      exp_addr_q.delete();
      occ = 0;
      outst = 0;
    end else begin
      hsv = (tvalid && tready) ? 1 : 0;
      if (hsv == 1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_row: got %0h want no row", tdata);
        end else begin
          e = exp_q.pop_front();
          chk("row", {tlast, tdata}, e);
        end
      end
      if (|enb) begin
        chk("enb_all", 65'(enb), 65'({BANKS{1'b1}}));
        chk("credit_gate", 65'(outst < FD), 65'(1));
        if (exp_addr_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL extra_read: got addrb %0h want no read", addrb);
        end else begin
          a8 = ADDR'(exp_addr_q.pop_front());
          ea = {BANKS{a8}};
          chk("addrb", 65'(addrb), 65'(ea));
        end
      end
      if (outst == FD) begin
        saw_stall = 1'b1;
        chk("stall_at_full_credit", 65'(enb), 65'(0));
      end
      outst = outst + ((|enb) ? 1 : 0) - hsv;
      occ   = occ + ((&validb) ? 1 : 0) - hsv;
      fifo_no_overflow: assert (occ <= FD)
        else $display("FAIL fifo_overflow: got %0d entries want <= %0d", occ, FD);
      if (occ > FD) begin
        total++;
        bad++;
      end
    end
  end

  initial begin
    tready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (mode)
        0:       tready = 1'b1;
        1:       tready = ~tready;
        default: tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic issue_cmd(input int unsigned base, input int unsigned len);
    for (int i = 0; i < int'(len); i++) begin
      int unsigned r;
      r = (base + i) % DEPTH;
      exp_q.push_back({(i == int'(len) - 1), row_word(r)});
      exp_addr_q.push_back(r);
    end
    base_addr = ADDR'(base);
    length    = LEN_W'(len);
    start     = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int first_enb, output int first_tv, output int k_last,
                           output int k_done, output int n_enb, output int n_hs);
    first_enb = 0; first_tv = 0; k_last = 0; k_done = 0; n_enb = 0; n_hs = 0;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (|enb) begin
        n_enb++;
        if (first_enb == 0) first_enb = k;
      end
      if (tvalid && first_tv == 0) first_tv = k;
      if (tvalid && tready) begin
        n_hs++;
        if (tlast) k_last = k;
      end
      if (done) begin
        k_done = k;
        break;
      end
    end
    if (k_done == 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done want done within 400 cycles");
    end else begin
      chk("busy_at_done", 65'(busy), 65'(0));
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, 65'({busy, done, enb, addrb, tvalid, tlast}), 65'(0));
  endtask

  initial begin
    int fe, ftv, kl, kd, ne, nh;
    int unsigned rb, rl;
    #2_000_000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe, ftv, kl, kd, ne, nh;
    int unsigned rb, rl;

    repeat (2) @(negedge clk);
    chk_reset_outputs("reset_state");
    #2 rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Basic command with timing
    mode = 0;
    issue_cmd(10, 5);
    chk("busy_after_start", 65'(busy), 65'(1));
    wait_done(fe, ftv, kl, kd, ne, nh);
    chk("t1_first_enb", 65'(fe), 65'(1));
    chk("t1_first_tvalid", 65'(ftv), 65'(3));
    chk("t1_rows", 65'(nh), 65'(5));
    chk("t1_reads", 65'(ne), 65'(5));
    chk("t1_back_to_back_rows", 65'(kl), 65'(ftv + 4));
    chk("t1_done_after_tlast", 65'(kd), 65'(kl + 1));
    @(negedge clk);
    chk("t1_done_pulse", 65'(done), 65'(0));

    // Address wrap
    issue_cmd(254, 4);
    wait_done(fe, ftv, kl, kd, ne, nh);
    chk("wrap_rows", 65'(nh), 65'(4));

    // Toggling backpressure plus an ignored start while busy
    mode = 1;
    saw_stall = 1'b0;
    issue_cmd(100, 8);
    start = 1'b1; base_addr = 8'd200; length = 9'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(fe, ftv, kl, kd, ne, nh);
    chk("toggle_sb_empty", 65'(exp_q.size()), 65'(0));
    chk("toggle_stall_seen", 65'(saw_stall), 65'(1));
    repeat (4) @(negedge clk);
    chk("no_queued_cmd", 65'(busy), 65'(0));

    // Zero-length command
    mode = 0;
    issue_cmd(5, 0);
    chk("len0_not_busy", 65'(busy), 65'(0));
    wait_done(fe, ftv, kl, kd, ne, nh);
    chk("len0_done_t1", 65'(kd), 65'(1));
    chk("len0_no_enb", 65'(ne), 65'(0));
    chk("len0_no_tvalid", 65'(ftv), 65'(0));

    // Back-to-back: second start lands in the done cycle
    issue_cmd(30, 2);
    wait_done(fe, ftv, kl, kd, ne, nh);
    issue_cmd(40, 3);
    wait_done(fe, ftv, kl, kd, ne, nh);
    chk("b2b_first_enb", 65'(fe), 65'(1));
    chk("b2b_rows", 65'(nh), 65'(3));

    // Reset mid-command
    mode = 2;
    issue_cmd(0, 16);
    repeat (6) @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("midcmd_reset");
    @(negedge clk);
    #2 rstn = 1'b1;
    mode = 0;
    issue_cmd(50, 2);
    wait_done(fe, ftv, kl, kd, ne, nh);
    chk("post_reset_rows", 65'(nh), 65'(2));
    chk("post_reset_sb_empty", 65'(exp_q.size()), 65'(0));

    // Random commands
    for (int n = 0; n < 8; n++) begin
      mode = $urandom_range(0, 2);
      rb = $urandom_range(0, DEPTH - 1);
      rl = $urandom_range(0, 12);
      issue_cmd(rb, rl);
      wait_done(fe, ftv, kl, kd, ne, nh);
      chk("rand_rows", 65'(nh), 65'(rl));
      chk("rand_reads", 65'(ne), 65'(rl));
    end

`ifdef MULTI_BANK_READER_CHECK_EN
    mode = 0;
    @(negedge clk);
    chk("err_clear", 65'(err), 65'(0));
    force_en = 1'b1; force_val = 4'b0111;
    @(negedge clk);
    force_en = 1'b0;
    @(negedge clk);
    chk("err_set", 65'(err), 65'(1));
    repeat (3) @(negedge clk);
    chk("err_sticky", 65'(err), 65'(1));
    #2 rstn = 1'b0;
    #1 chk("err_reset", 65'(err), 65'(0));
    @(negedge clk);
    #2 rstn = 1'b1;
`endif

    repeat (5) @(negedge clk);
    chk("final_sb_empty", 65'(exp_q.size() + exp_addr_q.size()), 65'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
